// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: PC sequencing, stall hold,
// jump/branch redirect with one-fetch squash, misalignment flag and fetch counter.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [31:0]          imem_addr,
  input  logic [31:0]          imem_rdata,
  input  logic                 stall,
  input  logic                 jump,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  output logic [31:0]          pc,
  output logic [31:0]          if_id_instr,
  output logic [31:0]          if_id_pc4,
  output logic                 if_id_valid,
  output logic [5:0]           opcode,
  output logic                 misalign_err,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  typedef enum logic [1:0] {
    ACT_FETCH,
    ACT_STALL,
    ACT_JUMP,
    ACT_BRANCH
  } action_t;

  action_t     action;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] redirect_target;
  logic        redirect;

  assign imem_addr   = pc;
  assign opcode      = if_id_instr[31:26];
  assign pc_plus4    = pc + 32'd4;
  assign jump_target = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00};

  // Branch is older than the instruction in IF/ID, so it beats a jump; any
  // redirect beats a stall because the stalled younger fetch is on the wrong path.
  always_comb begin
    action = ACT_FETCH;
    if (branch_taken)
      action = ACT_BRANCH;
    else if (jump && if_id_valid)
      action = ACT_JUMP;
    else if (stall)
      action = ACT_STALL;
  end

  always_comb begin
    redirect        = 1'b0;
    redirect_target = '0;
    case (action)
      ACT_BRANCH: begin
        redirect        = 1'b1;
        redirect_target = branch_target;
      end
      ACT_JUMP: begin
        redirect        = 1'b1;
        redirect_target = jump_target;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      if_id_instr  <= '0;
      if_id_pc4    <= '0;
      if_id_valid  <= 1'b0;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      misalign_err <= redirect && (redirect_target[1:0] != 2'b00);
      if (redirect) begin
        // Squash the fetch in flight; if_id_pc4 is left untouched on a bubble.
        pc          <= {redirect_target[31:2], 2'b00};
        if_id_instr <= '0;
        if_id_valid <= 1'b0;
      end else if (action == ACT_FETCH) begin
        pc          <= pc_plus4;
        if_id_instr <= imem_rdata;
        if_id_pc4   <= pc_plus4;
        if_id_valid <= 1'b1;
        fetch_count <= fetch_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule
